// File: rtl/rom_stream.sv
// rom_stream: burst sequencer that reads consecutive words from a synchronous
// ROM (1-cycle latency) and presents them on a valid/ready stream through a
// 2-entry skid FIFO. Supports non-power-of-2 address wrap, loop mode and abort.
module rom_stream #(
    parameter int VECTOR_LENGTH = 512,
    parameter int WORD_WIDTH    = 16,
    parameter int ADDR_WIDTH    = $clog2(VECTOR_LENGTH),
    parameter int LEN_WIDTH     = $clog2(VECTOR_LENGTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic                  loop_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  length_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    output logic                  rom_clke_o,
    input  logic [WORD_WIDTH-1:0] rom_data_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = ADDR_WIDTH'(VECTOR_LENGTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  cnt_q;
    logic                  loop_q;
    logic                  done_q;

    logic                  inflight_q;
    logic                  inflight_last_q;

    logic [WORD_WIDTH-1:0] fifo_data [2];
    logic                  fifo_last [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            occ;

    logic                  flush;
    logic                  push;
    logic                  pop;
    logic [1:0]            in_use;
    logic                  issue;
    logic                  issue_last;
    logic [ADDR_WIDTH-1:0] addr_next;

    // Issue/handshake decode. The pop of this cycle frees a slot, which is
    // what allows one word per cycle with only two buffer entries.
    always_comb begin
        flush      = abort_i && (state != ST_IDLE);
        push       = inflight_q && !flush;
        pop        = (occ != 2'd0) && ready_i;
        in_use     = occ + {1'b0, inflight_q} - {1'b0, pop};
        issue      = (state == ST_RUN) && !abort_i && (in_use < 2'd2);
        issue_last = (cnt_q == (len_q - LEN_ONE));
        addr_next  = (addr_q == ADDR_MAX) ? '0 : (addr_q + ADDR_ONE);
    end

    // Burst control FSM: captures the command, walks addresses, signals done.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state  <= ST_IDLE;
            base_q <= '0;
            addr_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            loop_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i && !abort_i) begin
                        if (length_i == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            base_q <= base_addr_i;
                            addr_q <= base_addr_i;
                            len_q  <= length_i;
                            loop_q <= loop_i;
                            cnt_q  <= '0;
                            state  <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort_i) begin
                        state <= ST_IDLE;
                    end else if (issue) begin
                        if (issue_last) begin
                            if (loop_q) begin
                                addr_q <= base_q;
                                cnt_q  <= '0;
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            addr_q <= addr_next;
                            cnt_q  <= cnt_q + LEN_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort_i) begin
                        state <= ST_IDLE;
                    end else if ((occ == 2'd0) && !inflight_q) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Track the single outstanding ROM read and its last-of-pass tag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue && issue_last;
        end
    end

    // Two-entry skid FIFO holding {data, last}; flushed on abort.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= rom_data_i;
                fifo_last[wr_ptr] <= inflight_last_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    assign busy_o     = (state != ST_IDLE);
    assign done_o     = done_q;
    assign valid_o    = (occ != 2'd0);
    assign data_o     = fifo_data[rd_ptr];
    assign last_o     = valid_o && fifo_last[rd_ptr];
    assign rom_addr_o = addr_q;
    assign rom_clke_o = issue;

endmodule

// File: tb/tb_rom_stream.sv
// tb_rom_stream: directed + randomized checks of rom_stream against a queue
// based reference of the expected word stream and address sequence.
module tb_rom_stream;

    localparam int VL  = 300;
    localparam int W   = 32;
    localparam int AW  = $clog2(VL);
    localparam int LW  = $clog2(VL + 1);
    localparam int VL8 = 5;
    localparam int W8  = 8;
    localparam int AW8 = $clog2(VL8);
    localparam int LW8 = $clog2(VL8 + 1);

    logic          clk_i = 1'b0;
    logic          rstn_i = 1'b0;
    logic          start_i = 1'b0;
    logic          loop_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [AW-1:0] base_addr_i = '0;
    logic [LW-1:0] length_i = '0;
    logic          busy_o;
    logic          done_o;
    logic [W-1:0]  data_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic          last_o;
    logic [AW-1:0] rom_addr_o;
    logic          rom_clke_o;
    logic [W-1:0]  rom_data_i;

    logic           a_start = 1'b0;
    logic           a_loop = 1'b0;
    logic           a_abort = 1'b0;
    logic [AW8-1:0] a_base = '0;
    logic [LW8-1:0] a_len = '0;
    logic           a_busy;
    logic           a_done;
    logic [W8-1:0]  a_data;
    logic           a_valid;
    logic           a_ready = 1'b0;
    logic           a_last;
    logic [AW8-1:0] a_rom_addr;
    logic           a_rom_clke;
    logic [W8-1:0]  a_rom_data;

    always #5 clk_i = ~clk_i;

    rom_stream #(.VECTOR_LENGTH(VL), .WORD_WIDTH(W)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .loop_i(loop_i),
        .abort_i(abort_i), .base_addr_i(base_addr_i), .length_i(length_i),
        .busy_o(busy_o), .done_o(done_o), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .last_o(last_o), .rom_addr_o(rom_addr_o),
        .rom_clke_o(rom_clke_o), .rom_data_i(rom_data_i)
    );

    rom_stream #(.VECTOR_LENGTH(VL8), .WORD_WIDTH(W8)) dut8 (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(a_start), .loop_i(a_loop),
        .abort_i(a_abort), .base_addr_i(a_base), .length_i(a_len),
        .busy_o(a_busy), .done_o(a_done), .data_o(a_data), .valid_o(a_valid),
        .ready_i(a_ready), .last_o(a_last), .rom_addr_o(a_rom_addr),
        .rom_clke_o(a_rom_clke), .rom_data_i(a_rom_data)
    );

    function automatic logic [31:0] rom_word(input int a);
        logic [31:0] av;
        av = a;
        return (av * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Synchronous ROM models: 1-cycle latency, output holds when not enabled.
    always @(posedge clk_i) if (rom_clke_o) rom_data_i <= W'(rom_word(int'(rom_addr_o)));
    always @(posedge clk_i) if (a_rom_clke) a_rom_data <= W8'(rom_word(int'(a_rom_addr)));

    int          vectors = 0;
    int          miscompares = 0;
    int          issued, popped, done_cnt, b_base, b_len;
    logic [31:0] exp_d[$];
    bit          exp_l[$];
    bit          prev_stall;
    logic [W-1:0] prev_data;
    logic        prev_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Build the expected stream for a burst and drive the start command.
    task automatic begin_burst(input int base, input int len, input bit lp, input int passes);
        exp_d.delete();
        exp_l.delete();
        issued = 0; popped = 0; done_cnt = 0; prev_stall = 0;
        b_base = base; b_len = len;
        for (int i = 0; i < len * passes; i++) begin
            exp_d.push_back(rom_word((base + i % len) % VL));
            exp_l.push_back((i % len) == len - 1);
        end
        start_i = 1'b1;
        base_addr_i = AW'(base);
        length_i = LW'(len);
        loop_i = lp;
    endtask

    // One cycle: drive inputs (control inputs scrambled), then check outputs.
    task automatic step(input bit rdy);
        @(negedge clk_i);
        start_i = 1'b0;
        abort_i = 1'b0;
        ready_i = rdy;
        base_addr_i = AW'($urandom_range(0, VL - 1));
        length_i = LW'($urandom_range(0, VL));
        loop_i = 1'($urandom);
        #1;
        if (done_o) done_cnt++;
        if (prev_stall) begin
            chk("stall_valid", valid_o, 1);
            chk("stall_data", data_o, prev_data);
            chk("stall_last", last_o, prev_last);
        end
        if (rom_clke_o) begin
            if (b_len == 0) chk("spurious_read", 1, 0);
            else chk("rom_addr", rom_addr_o, (b_base + issued % b_len) % VL);
            issued++;
        end
        if (valid_o && ready_i) begin
            if (exp_d.size() == 0) chk("extra_word", 1, 0);
            else begin
                chk("data", data_o, exp_d.pop_front());
                chk("last", last_o, exp_l.pop_front());
            end
            popped++;
        end
        chk("outstanding_le2", (issued - popped) <= 2, 1);
        prev_stall = valid_o && !ready_i;
        prev_data = data_o;
        prev_last = last_o;
    endtask

    task automatic run_until_idle(input int budget, input bit rand_ready);
        for (int n = 0; n < budget; n++) begin
            step(rand_ready ? 1'($urandom) : 1'b1);
            if (!busy_o && !valid_o) break;
        end
        chk("burst_finished", busy_o, 0);
    endtask

    task automatic check_burst_end(input string tag, input int len);
        chk({tag, "_count"}, popped, len);
        chk({tag, "_leftover"}, exp_d.size(), 0);
        chk({tag, "_done"}, done_cnt, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int adone;

        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_last", last_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_clke", rom_clke_o, 0);
        chk("rst_addr", rom_addr_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Basic burst with latency and back-to-back delivery.
        begin_burst(10, 4, 0, 1);
        step(1); chk("lat_edge1_valid", valid_o, 0); chk("lat_busy", busy_o, 1);
        step(1); chk("lat_edge2_valid", valid_o, 0);
        step(1); chk("lat_edge3_valid", valid_o, 1);
        step(1); step(1); step(1);
        chk("consecutive_words", popped, 4);
        run_until_idle(20, 0);
        check_burst_end("basic", 4);

        // Wrap at non-power-of-2 depth.
        begin_burst(298, 4, 0, 1);
        run_until_idle(20, 0);
        check_burst_end("wrap", 4);

        // Random backpressure.
        begin_burst($urandom_range(0, VL - 1), 8, 0, 1);
        run_until_idle(300, 1);
        check_burst_end("bp8", 8);

        // Random bursts with random backpressure.
        for (int r = 0; r < 6; r++) begin
            int l;
            l = $urandom_range(1, 40);
            begin_burst($urandom_range(0, VL - 1), l, 0, 1);
            run_until_idle(600, 1);
            check_burst_end("rand", l);
        end

        // Loop mode then abort.
        begin_burst(5, 3, 1, 5);
        for (int n = 0; n < 40; n++) begin
            step(1);
            if (popped == 10) break;
        end
        chk("loop_count", popped, 10);
        chk("loop_busy", busy_o, 1);
        chk("loop_no_done", done_cnt, 0);
        abort_i = 1'b1;
        step(1);
        chk("abort_valid", valid_o, 0);
        chk("abort_busy", busy_o, 0);
        repeat (3) step(1);
        chk("abort_valid_later", valid_o, 0);
        chk("abort_no_done", done_cnt, 0);

        // Zero length: done pulse only.
        begin_burst(7, 0, 0, 0);
        step(1);
        chk("len0_done", done_o, 1);
        chk("len0_busy", busy_o, 0);
        step(1);
        chk("len0_done_cleared", done_o, 0);
        repeat (3) step(1);
        chk("len0_no_words", popped, 0);
        chk("len0_done_once", done_cnt, 1);

        // Start while busy is ignored.
        begin_burst(20, 6, 0, 1);
        step(1); step(1);
        start_i = 1'b1; base_addr_i = AW'(100); length_i = LW'(2); loop_i = 1'b0;
        run_until_idle(40, 0);
        check_burst_end("start_busy", 6);

        // Full-length burst.
        begin_burst(123, VL, 0, 1);
        run_until_idle(VL + 40, 0);
        check_burst_end("full", VL);

        // Asynchronous reset mid-burst.
        begin_burst(50, 20, 0, 1);
        repeat (4) step(1);
        rstn_i = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_last", last_o, 0);
        chk("mid_rst_data", data_o, 0);
        chk("mid_rst_clke", rom_clke_o, 0);
        chk("mid_rst_addr", rom_addr_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        b_len = 0;
        repeat (3) step(1);
        chk("post_rst_valid", valid_o, 0);
        chk("post_rst_no_done", done_cnt, 0);

        // 8-bit instance: full-length burst starting mid-array.
        a_base = AW8'(3); a_len = LW8'(VL8); a_start = 1'b1; a_ready = 1'b1;
        k = 0; adone = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            a_start = 1'b0;
            #1;
            if (a_done) adone++;
            if (a_valid && a_ready) begin
                chk("w8_data", a_data, W8'(rom_word((3 + k) % VL8)));
                chk("w8_last", a_last, k == VL8 - 1);
                k++;
            end
        end
        chk("w8_count", k, VL8);
        chk("w8_done", adone, 1);
        chk("w8_idle", a_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rom_stream.md
Name: rom_stream

Overview:
- Parametrised ROM sequencer: on a start command, fetches `length_i` consecutive words from a synchronous ROM, beginning at `base_addr_i`.
- Presents the words on a valid/ready stream with full backpressure.
- Successor to the fixed single-address ROM read path: adds burst fetch, non-power-of-2 address wrap, loop mode, abort and a 1-word/cycle skid buffer.
- Sits between a ROM macro (1-cycle read latency, clock-enable hold) and a byte/word sink such as a USB IN endpoint FIFO.

Parameters:
- VECTOR_LENGTH, 512, number of ROM words (any value ≥ 2, not necessarily a power of 2).
- WORD_WIDTH, 16, data width (8, 16 or 32).
- ADDR_WIDTH, ceil_log2(VECTOR_LENGTH), ROM address width.
- LEN_WIDTH, ceil_log2(VECTOR_LENGTH+1), burst length width.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  start a burst; sampled only in IDLE.
- loop_i  in  1  loop mode; sampled together with start_i.
- abort_i  in  1  terminate the current burst.
- base_addr_i  in  ADDR_WIDTH  first word address; sampled with start_i.
- length_i  in  LEN_WIDTH  words per pass; sampled with start_i.
- busy_o  out  1  high when not IDLE.
- done_o  out  1  one-cycle pulse at completion of a non-loop burst.
- data_o  out  WORD_WIDTH  stream data.
- valid_o  out  1  stream valid.
- ready_i  in  1  stream ready.
- last_o  out  1  qualifies the final word of each pass.
- rom_addr_o  out  ADDR_WIDTH  ROM read address.
- rom_clke_o  out  1  ROM read enable / clock enable.
- rom_data_i  in  WORD_WIDTH  ROM data.

Behaviour:
- Reset values: busy_o=0, done_o=0, valid_o=0, last_o=0, data_o=0, rom_clke_o=0, rom_addr_o=0. The FIFO is emptied and the FSM goes to IDLE.
- ROM contract:
  - A read is issued in a cycle with rom_clke_o=1 at rom_addr_o.
  - rom_data_i is valid after the next rising edge.
  - rom_data_i holds while rom_clke_o=0.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on start_i=1 with length_i≠0. Capture base, length and loop; clear the issue counter.
  - IDLE: start_i=1 with length_i=0 pulses done_o in the next cycle. No data is produced and the FSM stays IDLE.
  - RUN issues one read per cycle while (FIFO occupancy + reads in flight) < 2.
  - The address sequence is base, base+1, … Past VECTOR_LENGTH-1 it wraps to 0 (modulo VECTOR_LENGTH, not 2^ADDR_WIDTH).
  - Each read carries a "last" tag, set on issue count = length-1.
  - RUN→DRAIN after issuing the last read when loop=0.
  - With loop=1, RUN stays in RUN: after the last read the address reloads to base, the count clears, and issuing continues with no bubble.
  - DRAIN→IDLE when the FIFO is empty and no read is in flight. done_o pulses in that same transition cycle.
- Skid FIFO:
  - 2 entries of {data, last}.
  - A returning word is pushed the cycle after its issue.
  - The head drives data_o/last_o; valid_o = FIFO non-empty.
  - Pop on valid_o & ready_i.
  - Push and pop in the same cycle are allowed.
- Throughput and latency:
  - ready_i held high gives 1 word/cycle sustained.
  - The first valid_o rises after the 2nd rising edge following the edge that samples start_i.
- Backpressure:
  - data_o/last_o stay stable while valid_o=1 and ready_i=0.
  - No word is dropped or duplicated.
  - rom_clke_o=0 whenever the issue condition fails.
- Abort:
  - abort_i=1 in RUN/DRAIN returns the FSM to IDLE on the next edge.
  - The FIFO is flushed and the in-flight read is discarded.
  - valid_o=0 from the next cycle; done_o is not pulsed.
  - abort_i in IDLE is ignored; abort_i takes priority over start_i.
- Control-input rules:
  - start_i while busy is ignored.
  - Changes to base_addr_i, length_i or loop_i while busy have no effect.
- length_i = VECTOR_LENGTH is legal and reads every word once, wrapping as needed.
- Asynchronous reset mid-burst clears everything immediately. No done pulse is produced.

Test Plan:
- Basic burst: VECTOR_LENGTH=512, base=10, len=4, ready_i=1 → words @10..13 on 4 consecutive cycles. First valid_o is 2 edges after start. last_o only on @13, done_o pulses once, busy_o drops.
- Wrap at a non-power-of-2 depth: VECTOR_LENGTH=300, base=298, len=4 → addresses 298, 299, 0, 1 in order; last_o on word @1.
- Backpressure: len=8, ready_i toggled by a random 50% pattern → exactly 8 words in order. data_o stable during stalls, FIFO never overflows, rom_clke_o=0 on stalled cycles.
- Loop mode: loop=1, base=5, len=3, ready_i=1 for 10 beats → 5,6,7,5,6,7,5,6,7,5. last_o on every @7, no done_o. Then abort_i → valid_o=0 next cycle, busy_o=0, no done_o.
- Edge cases:
  - len=0 → done_o pulse one cycle after start, valid_o never rises.
  - start_i while busy → ignored, burst unchanged.
  - rstn_i=0 mid-burst → all outputs 0 immediately.
- Width modes: WORD_WIDTH=8 and 32, len=VECTOR_LENGTH → every ROM word emitted exactly once, last_o on the final word.
